// File: rtl/serial_addsub_if.sv
// Start/done handshake and operand/result bundle
// for the bit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int N = 4
);
  logic         start;
  logic         SUB;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] SUM;
  logic         Cout;
  logic         OVF;

  modport master (
    output start, SUB, A, B, Cin,
    input  busy, done, SUM, Cout, OVF
  );

  modport slave (
    input  start, SUB, A, B, Cin,
    output busy, done, SUM, Cout, OVF
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one full-adder
// slice reused LSB first, result after N+1 cycles.
module serial_addsub #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_addsub_if.slave bus
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-2:0]  r_sr;
  logic [N-1:0]  sum_q;
  logic [CW-1:0] cnt;
  logic          c;
  logic          cout_q;
  logic          ovf_q;

  logic accept;
  logic last;
  logic s;
  logic c_nx;
  logic busy;
  logic done;

  // DONE accepts start too, so back-to-back ops lose no cycle
  assign accept = bus.start &&
                  (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  assign s    = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nx = (a_sr[0] & b_sr[0]) |
                (a_sr[0] & c) |
                (b_sr[0] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = accept ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_sr <= bus.A;
        b_sr <= bus.SUB ? ~bus.B : bus.B;
        c    <= bus.Cin ^ bus.SUB;
        r_sr <= '0;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= (N-1)'({s, r_sr} >> 1);
        c    <= c_nx;
        if (!last) cnt <= cnt + CW'(1);
      end
      // c here is the carry into the MSB
      if (last) begin
        sum_q  <= {s, r_sr};
        cout_q <= c_nx;
        ovf_q  <= c ^ c_nx;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.SUM  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: cycle model
// plus directed literal cases and random traffic.
module tb_serial_addsub;

  localparam int N = 4;
  localparam int M = 1 << N;
  localparam int H = 1 << (N - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_addsub_if #(.N(N)) bus ();

  serial_addsub #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // reference arithmetic from integer values
  function automatic void calc(input logic [N-1:0] a,
                               input logic [N-1:0] b,
                               input logic cin,
                               input logic sub,
                               output logic [N-1:0] s,
                               output logic co,
                               output logic ov);
    int ia, ib, sa, sb, r, sr;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= H) ? ia - M : ia;
    sb = (ib >= H) ? ib - M : ib;
    if (!sub) begin
      r  = ia + ib + int'(cin);
      co = (r >= M);
      sr = sa + sb + int'(cin);
    end else begin
      r  = ia - ib - int'(cin);
      co = (r >= 0);
      sr = sa - sb - int'(cin);
    end
    s  = N'(r);
    ov = (sr > H - 1) || (sr < -H);
  endfunction

  // phase 0 idle, 1..N running, N+1 done
  int phase = 0;
  logic [N-1:0] m_sum = '0;
  logic m_cout = 1'b0;
  logic m_ovf = 1'b0;
  logic [N-1:0] p_sum;
  logic p_cout;
  logic p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      phase  = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if ((phase == 0 || phase == N + 1) && bus.start) begin
      calc(bus.A, bus.B, bus.Cin, bus.SUB, p_sum, p_cout, p_ovf);
      phase = 1;
    end else if (phase == N + 1) begin
      phase = 0;
    end else if (phase != 0) begin
      phase++;
      if (phase == N + 1) begin
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", 32'(bus.busy), 32'(phase != 0));
      chk("m_done", 32'(bus.done), 32'(phase == N + 1));
      chk("m_sum", 32'(bus.SUM), 32'(m_sum));
      chk("m_cout", 32'(bus.Cout), 32'(m_cout));
      chk("m_ovf", 32'(bus.OVF), 32'(m_ovf));
    end
  end

  task automatic drive(input logic [N-1:0] a,
                       input logic [N-1:0] b,
                       input logic cin,
                       input logic sub);
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.SUB = sub;
    bus.start = 1'b1;
  endtask

  task automatic scramble();
    bus.start = 1'b0;
    bus.A = N'($urandom);
    bus.B = N'($urandom);
    bus.Cin = 1'($urandom);
    bus.SUB = 1'($urandom);
  endtask

  task automatic do_op(input logic [N-1:0] a,
                       input logic [N-1:0] b,
                       input logic cin,
                       input logic sub,
                       input logic [N-1:0] es,
                       input logic ec,
                       input logic eo,
                       input string nm);
    int cyc;
    @(negedge clk);
    drive(a, b, cin, sub);
    @(negedge clk);
    scramble();
    cyc = 1;
    while (!bus.done && cyc < N + 4) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(N + 1));
    chk({nm, "_sum"}, 32'(bus.SUM), 32'(es));
    chk({nm, "_cout"}, 32'(bus.Cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(bus.OVF), 32'(eo));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int k1;
    int k2;
    logic [N-1:0] cap;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.SUB = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.SUM), 32'd0);
    chk("rst_cout", 32'(bus.Cout), 32'd0);
    chk("rst_ovf", 32'(bus.OVF), 32'd0);
    rst = 1'b0;

    do_op(4'b0101, 4'b0011, 1'b0, 1'b0,
          4'b1000, 1'b0, 1'b1, "add1");
    do_op(4'b1111, 4'b1111, 1'b1, 1'b0,
          4'b1111, 1'b1, 1'b0, "add_full");
    do_op(4'b1010, 4'b1010, 1'b1, 1'b0,
          4'b0101, 1'b1, 1'b1, "add_ovf");
    do_op(4'b0101, 4'b0011, 1'b0, 1'b1,
          4'b0010, 1'b1, 1'b0, "sub1");
    do_op(4'b0011, 4'b0101, 1'b0, 1'b1,
          4'b1110, 1'b0, 1'b0, "sub_borrow");
    do_op(4'b1000, 4'b0001, 1'b0, 1'b1,
          4'b0111, 1'b1, 1'b1, "sub_ovf");

    // start during RUN must be ignored
    @(negedge clk);
    drive(4'b0101, 4'b0011, 1'b0, 1'b0);
    ndone = 0;
    k1 = -1;
    cap = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) drive(4'b1111, 4'b0001, 1'b1, 1'b1);
      else scramble();
      if (bus.done) begin
        ndone++;
        k1 = k;
        cap = bus.SUM;
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_lat", 32'(k1), 32'(N + 1));
    chk("ign_sum", 32'(cap), 32'(4'b1000));

    // back-to-back: restart on the done cycle
    @(negedge clk);
    drive(4'b0101, 4'b0011, 1'b0, 1'b0);
    ndone = 0;
    k1 = -1;
    k2 = -1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (k1 < 0) k1 = k;
        else k2 = k;
      end
      if (k > N + 1 && k < 2 * N + 2)
        chk("b2b_hold", 32'(bus.SUM), 32'(4'b1000));
      if (k == 2 * N + 2)
        chk("b2b_sum2", 32'(bus.SUM), 32'(4'b0111));
      if (k == N + 1) drive(4'b1000, 4'b0001, 1'b0, 1'b1);
      else scramble();
    end
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_k1", 32'(k1), 32'(N + 1));
    chk("b2b_k2", 32'(k2), 32'(2 * N + 2));

    // reset during the second RUN cycle
    @(negedge clk);
    drive(4'b0110, 4'b0011, 1'b1, 1'b0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_sum", 32'(bus.SUM), 32'd0);
    chk("mrst_cout", 32'(bus.Cout), 32'd0);
    chk("mrst_ovf", 32'(bus.OVF), 32'd0);
    ndone = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    do_op(4'b0110, 4'b0011, 1'b1, 1'b0,
          4'b1010, 1'b0, 1'b1, "post_rst");

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.A = N'($urandom);
      bus.B = N'($urandom);
      bus.Cin = 1'($urandom);
      bus.SUB = 1'($urandom);
      bus.start = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2 * N) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
